// File: rtl/icache_2way_pkg.sv
// icache_2way_pkg: shared constants and types for the two-way instruction cache.
//   Geometry: 64 sets x 2 ways x 32 words of 32 bits (128-byte lines).
//   Address split: tag [31:13], index [12:7], word offset [6:2], byte offset [1:0].
//   Also holds the cache FSM state enum and the fixed AXI burst attributes.
package icache_2way_pkg;

  localparam int ICACHE_WAYS       = 2;
  localparam int ICACHE_SETS       = 64;
  localparam int ICACHE_LINE_WORDS = 32;
  localparam int TAG_W             = 19;
  localparam int INDEX_W           = 6;
  localparam int OFFSET_W          = 5;

  // One INCR burst of 32 beats, 4 bytes each, fetches a whole line.
  localparam logic [7:0] AXI_ARLEN   = 8'd31;
  localparam logic [2:0] AXI_ARSIZE  = 3'b010;
  localparam logic [1:0] AXI_ARBURST = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_RESP = 2'd3
  } icache_state_e;

  // Line-aligned byte address of a line.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0]   tag,
                                            input logic [INDEX_W-1:0] index);
    return {tag, index, 7'b0};
  endfunction

endpackage

// File: rtl/icache_way.sv
// icache_way: storage for one way of the cache.
//   Ports:
//     clk, rst_n        clock, async active-low reset (clears valid bits only)
//     rd_index/rd_word  lookup set and word; rd_valid/rd_tag/rd_data are
//                       combinational reads of that set/word
//     wr_en, wr_index,  line-fill word write (one word per cycle)
//     wr_word, wr_data
//     tag_wr_en,        writes tag and valid of set wr_index; used with
//     tag_wr_valid,     tag_wr_valid=0 to invalidate a victim before its fill
//     tag_wr            and with tag_wr_valid=1 to publish the filled line
module icache_way
  import icache_2way_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_word,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [31:0]         rd_data,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_word,
  input  logic [31:0]         wr_data,
  input  logic                tag_wr_en,
  input  logic                tag_wr_valid,
  input  logic [TAG_W-1:0]    tag_wr
);

  logic [ICACHE_SETS-1:0] valid_q;
  logic [ICACHE_SETS-1:0] valid_d;

  // Tag and data arrays carry no reset: a line is only trusted through valid_q.
  logic [TAG_W-1:0] tag_mem  [ICACHE_SETS];
  logic [31:0]      data_mem [ICACHE_SETS*ICACHE_LINE_WORDS];

  always_comb begin
    valid_d = valid_q;
    if (tag_wr_en) begin
      valid_d[wr_index] = tag_wr_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_index, wr_word}] <= wr_data;
    end
    if (tag_wr_en) begin
      tag_mem[wr_index] <= tag_wr;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_word}];

endmodule

// File: rtl/icache_2way.sv
// icache_2way: two-way set-associative read-only instruction cache.
//   Fetch side: req_valid/req_addr in (held until resp_valid), resp_valid is a
//   one-cycle pulse with resp_data in the same cycle. Hits answer one cycle
//   after the request is sampled; misses fetch the whole line with a single
//   AXI INCR burst, fill the victim way (invalid first, then LRU) and answer.
//   AXI read side: araddr/arvalid/arlen/arsize/arburst out, arready in;
//   rdata/rresp/rvalid/rlast in, rready out. rresp is ignored.
//   dbg_state exposes the FSM state.
//   Optional feature macro ICACHE_PERF_CNT_EN adds hit_cnt/miss_cnt outputs.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high; arvalid and araddr stay constant from assertion until that edge,
//   and rready is high for the whole of state R.
module icache_2way
  import icache_2way_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready,
  output logic [1:0]  dbg_state
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  icache_state_e state_q, state_d;

  logic [TAG_W-1:0]    req_tag_q, req_tag_d;
  logic [INDEX_W-1:0]  req_index_q, req_index_d;
  logic [OFFSET_W-1:0] req_word_q, req_word_d;
  logic                victim_q, victim_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic                arvalid_q, arvalid_d;
  logic [31:0]         araddr_q, araddr_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic [ICACHE_SETS-1:0] lru_q, lru_d;

  // Lookup always uses the live request address, which is stable while
  // req_valid is high.
  logic [TAG_W-1:0]    lk_tag;
  logic [INDEX_W-1:0]  lk_index;
  logic [OFFSET_W-1:0] lk_word;

  assign lk_tag   = req_addr[31:13];
  assign lk_index = req_addr[12:7];
  assign lk_word  = req_addr[6:2];

  logic [ICACHE_WAYS-1:0] way_valid;
  logic [TAG_W-1:0]       way_tag  [ICACHE_WAYS];
  logic [31:0]            way_data [ICACHE_WAYS];
  logic [ICACHE_WAYS-1:0] way_hit;
  logic [ICACHE_WAYS-1:0] way_wr_en;
  logic [ICACHE_WAYS-1:0] way_tag_wr_en;
  logic                   tag_wr_valid_s;
  logic [INDEX_W-1:0]     wr_index_s;
  logic                   lk_hit;
  logic                   lk_victim;

  for (genvar w = 0; w < ICACHE_WAYS; w++) begin : g_way
    icache_way u_way (
      .clk          (clk),
      .rst_n        (rst_n),
      .rd_index     (lk_index),
      .rd_word      (lk_word),
      .rd_valid     (way_valid[w]),
      .rd_tag       (way_tag[w]),
      .rd_data      (way_data[w]),
      .wr_en        (way_wr_en[w]),
      .wr_index     (wr_index_s),
      .wr_word      (beat_q),
      .wr_data      (rdata),
      .tag_wr_en    (way_tag_wr_en[w]),
      .tag_wr_valid (tag_wr_valid_s),
      .tag_wr       (req_tag_q)
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == lk_tag);
  end

  assign lk_hit = |way_hit;

  // Invalid ways are filled first; with both valid, evict the LRU way.
  always_comb begin
    if (!way_valid[0]) begin
      lk_victim = 1'b0;
    end else if (!way_valid[1]) begin
      lk_victim = 1'b1;
    end else begin
      lk_victim = lru_q[lk_index];
    end
  end

  always_comb begin
    state_d        = state_q;
    req_tag_d      = req_tag_q;
    req_index_d    = req_index_q;
    req_word_d     = req_word_q;
    victim_d       = victim_q;
    beat_d         = beat_q;
    arvalid_d      = arvalid_q;
    araddr_d       = araddr_q;
    resp_data_d    = resp_data_q;
    lru_d          = lru_q;
    way_wr_en      = '0;
    way_tag_wr_en  = '0;
    tag_wr_valid_s = 1'b0;
    wr_index_s     = req_index_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_tag_d   = lk_tag;
          req_index_d = lk_index;
          req_word_d  = lk_word;
          if (lk_hit) begin
            resp_data_d     = way_hit[1] ? way_data[1] : way_data[0];
            lru_d[lk_index] = ~way_hit[1];
            state_d         = S_RESP;
          end else begin
            // The victim is invalidated up front so a line being refilled
            // can never be mistaken for the line it replaces.
            victim_d                 = lk_victim;
            wr_index_s               = lk_index;
            way_tag_wr_en[lk_victim] = 1'b1;
            tag_wr_valid_s           = 1'b0;
            araddr_d                 = line_addr(lk_tag, lk_index);
            arvalid_d                = 1'b1;
            beat_d                   = '0;
            state_d                  = S_AR;
          end
        end
      end

      S_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = S_R;
        end
      end

      S_R: begin
        if (rvalid) begin
          way_wr_en[victim_q] = 1'b1;
          beat_d              = beat_q + 5'd1;
          if (beat_q == req_word_q) begin
            resp_data_d = rdata;
          end
          // rlast alone ends the fill, whatever the beat count.
          if (rlast) begin
            way_tag_wr_en[victim_q] = 1'b1;
            tag_wr_valid_s          = 1'b1;
            lru_d[req_index_q]      = ~victim_q;
            state_d                 = S_RESP;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_tag_q   <= '0;
      req_index_q <= '0;
      req_word_q  <= '0;
      victim_q    <= 1'b0;
      beat_q      <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      resp_data_q <= '0;
      lru_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      req_index_q <= req_index_d;
      req_word_q  <= req_word_d;
      victim_q    <= victim_d;
      beat_q      <= beat_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      resp_data_q <= resp_data_d;
      lru_q       <= lru_d;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_IDLE && req_valid) begin
      if (lk_hit) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  // Burst attributes never change, so constants are as stable as a register.
  assign arlen      = AXI_ARLEN;
  assign arsize     = AXI_ARSIZE;
  assign arburst    = AXI_ARBURST;
  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = (state_q == S_R);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_data_q;
  assign dbg_state  = state_q;

  logic unused_inputs;
  assign unused_inputs = ^{rresp, req_addr[1:0]};

endmodule

// File: tb/tb_icache_2way.sv
// tb_icache_2way: directed test of icache_2way against an AXI memory model
// whose word at byte address A is 32'h5A5A_0000 | A (all addresses < 64 KiB).
module tb_icache_2way;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic [1:0]  dbg_state;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_2way dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rlast      (rlast),
    .rready     (rready),
    .dbg_state  (dbg_state)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- shared state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          ar_count = 0;
  int          beats_sent = 0;
  logic [31:0] exp_araddr = '0;
  logic [31:0] mon_exp;
  int          exp_hits = 0;
  int          exp_misses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- AXI read slave ----------------
  initial begin : axi_slave
    int          phase;
    int          delay;
    int          beat;
    logic [31:0] sl_base;
    phase = 0; delay = -1; beat = 0; sl_base = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0; delay = -1; beat = 0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      end else if (phase == 0) begin
        if (arready) begin
          // address handshake happened on the edge just passed
          arready = 1'b0;
          phase   = 1;
          beat    = 0;
        end else if (arvalid) begin
          if (delay < 0) delay = $urandom_range(0, 2);
          if (delay == 0) begin
            arready = 1'b1;
            ar_count++;
            sl_base = araddr;
            check("araddr", araddr, exp_araddr);
            check("arlen", 32'(arlen), 32'd31);
            check("arsize", 32'(arsize), 32'd2);
            check("arburst", 32'(arburst), 32'd1);
            delay = -1;
          end else begin
            delay--;
          end
        end
      end else begin
        // a beat presented with rready high was taken on the edge just passed
        if (rvalid) begin
          beat++;
          beats_sent++;
        end
        if (rvalid && rlast) begin
          rvalid = 1'b0;
          rlast  = 1'b0;
          phase  = 0;
        end else if (rready && $urandom_range(0, 3) != 0) begin
          rvalid = 1'b1;
          rdata  = 32'h5A5A_0000 | (sl_base + 32'(beat * 4));
          rresp  = 2'($urandom_range(0, 3));
          rlast  = (beat == 31);
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got %h expected no response", resp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("resp_data", resp_data, mon_exp);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic [31:0] addr, input logic [31:0] data, input bit miss);
    int ar_before;
    int cyc;
    @(negedge clk);
    exp_araddr = addr & 32'hFFFF_FF80;
    exp_q.push_back(data);
    if (miss) exp_misses++; else exp_hits++;
    ar_before = ar_count;
    req_valid = 1'b1;
    req_addr  = addr;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 2000);
    req_valid = 1'b0;
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no resp after %0d cycles expected resp for %h", cyc, addr);
    end
    check("ar_issued", 32'(ar_count - ar_before), miss ? 32'd1 : 32'd0);
    if (miss) check("miss_latency_min", 32'(cyc >= 34), 32'd1);
    else      check("hit_latency", 32'(cyc), 32'd1);
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  localparam int NV = 15;
  logic [31:0] v_addr [NV];
  logic [31:0] v_data [NV];
  bit          v_miss [NV];

  initial begin : main
    int b0;
    int cyc;
    v_addr = '{32'h0088, 32'h0088, 32'h2088, 32'h4088, 32'h2088,
               32'h0088, 32'h4088, 32'h008C, 32'h00FC, 32'h0080,
               32'h4088, 32'h1F80, 32'h1FFC, 32'h2088, 32'h0088};
    v_data = '{32'h5A5A_0088, 32'h5A5A_0088, 32'h5A5A_2088, 32'h5A5A_4088, 32'h5A5A_2088,
               32'h5A5A_0088, 32'h5A5A_4088, 32'h5A5A_008C, 32'h5A5A_00FC, 32'h5A5A_0080,
               32'h5A5A_4088, 32'h5A5A_1F80, 32'h5A5A_1FFC, 32'h5A5A_2088, 32'h5A5A_0088};
    v_miss = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      do_req(v_addr[i], v_data[i], v_miss[i]);
    end

    // reset in the middle of a line fill
    @(negedge clk);
    exp_araddr = 32'h0000_0180;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0188;
    b0  = beats_sent;
    cyc = 0;
    while ((beats_sent - b0) < 10 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("midfill_reached", 32'((beats_sent - b0) >= 10), 32'd1);
    check("midfill_rready", 32'(rready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_resp_data", resp_data, 32'd0);
    check("midrst_arvalid", 32'(arvalid), 32'd0);
    check("midrst_rready", 32'(rready), 32'd0);
    check("midrst_araddr", araddr, 32'd0);
    req_valid = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_req(32'h0000_0188, 32'h5A5A_0188, 1'b1);
    do_req(32'h0000_0088, 32'h5A5A_0088, 1'b1);
    do_req(32'h0000_01FC, 32'h5A5A_01FC, 1'b0);

    repeat (5) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt, 32'(exp_hits));
    check("miss_cnt", miss_cnt, 32'(exp_misses));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
